// File: rtl/btb_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Lookup is combinational on F_PC; training from Execute lands at the next clock edge.
// Optional gshare direction (global history XOR index into a PHT) under `BTB_GSHARE_EN.
module btb_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] F_PC,
  output logic        F_prediction_made,
  output logic        F_predicted_taken,
  output logic [31:0] F_btb_PCtarget,
  input  logic        E_valid,
  input  logic [31:0] E_PC,
  input  logic        E_branch,
  input  logic        E_jal,
  input  logic        E_jalr,
  input  logic        E_taken,
  input  logic [31:0] E_PCTarget
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic                  is_jal_q [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx, e_idx;
  logic [TAG_BITS-1:0]   f_tag, e_tag;
  logic                  f_hit, e_hit;
  logic [1:0]            f_ctr;

  // Word-offset bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{F_PC[1:0], E_PC[1:0]};

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    else    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  assign f_idx = F_PC[INDEX_BITS+1:2];
  assign f_tag = F_PC[31:INDEX_BITS+2];
  assign e_idx = E_PC[INDEX_BITS+1:2];
  assign e_tag = E_PC[31:INDEX_BITS+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

`ifdef BTB_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q;
  logic [1:0]            pht_q [ENTRIES];
  logic [INDEX_BITS-1:0] e_pht_idx;
  logic [INDEX_BITS:0]   ghr_shift;

  assign f_ctr     = pht_q[f_idx ^ ghr_q];
  assign e_pht_idx = e_idx ^ ghr_q;
  assign ghr_shift = {ghr_q, E_taken};

  // Global history and pattern table train on every resolved conditional branch, hit or miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
    end else if (E_valid && E_branch) begin
      pht_q[e_pht_idx] <= sat_step(pht_q[e_pht_idx], E_taken);
      ghr_q            <= ghr_shift[INDEX_BITS-1:0];
    end
  end
`else
  assign f_ctr = ctr_q[f_idx];
`endif

  // Lookup reflects state before any same-cycle update.
  assign F_prediction_made = f_hit;
  assign F_predicted_taken = f_hit && (f_ctr[1] || is_jal_q[f_idx]);
  assign F_btb_PCtarget    = f_hit ? target_q[f_idx] : 32'h0;

  // Control fields: valid, counter and JAL flag per entry; reset overrides any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        is_jal_q[i] <= 1'b0;
      end
    end else if (E_valid) begin
      if (E_jal) begin
        valid_q[e_idx]  <= 1'b1;
        ctr_q[e_idx]    <= 2'b11;
        is_jal_q[e_idx] <= 1'b1;
      end else if (E_branch) begin
        if (e_hit) begin
          ctr_q[e_idx]    <= sat_step(ctr_q[e_idx], E_taken);
          is_jal_q[e_idx] <= 1'b0;
        end else if (E_taken) begin
          valid_q[e_idx]  <= 1'b1;
          ctr_q[e_idx]    <= 2'b10;
          is_jal_q[e_idx] <= 1'b0;
        end
      end else if (E_jalr && e_hit) begin
        // JALR targets are data dependent; drop an aliasing entry rather than mispredict.
        valid_q[e_idx] <= 1'b0;
      end
    end
  end

  // Tag and target carry no reset value; written on JAL and on any taken branch.
  always_ff @(posedge clk) begin
    if (!rst && E_valid && (E_jal || (E_branch && E_taken))) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= E_PCTarget;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: lookup expectations are queued as each
// F_PC is driven and popped when the combinational outputs are sampled.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] F_PC;
  logic        F_prediction_made;
  logic        F_predicted_taken;
  logic [31:0] F_btb_PCtarget;
  logic        E_valid;
  logic [31:0] E_PC;
  logic        E_branch;
  logic        E_jal;
  logic        E_jalr;
  logic        E_taken;
  logic [31:0] E_PCTarget;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_BR = 2'd0, OP_JAL = 2'd1, OP_JALR = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  op;
    logic        tk;
    logic [31:0] tgt;
    logic        em;
    logic        et;
    logic [31:0] etg;
  } step_t;

  logic [33:0] sb[$];
  logic [33:0] got, want;

  always #5 clk = ~clk;

  btb_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .F_PC(F_PC),
    .F_prediction_made(F_prediction_made), .F_predicted_taken(F_predicted_taken),
    .F_btb_PCtarget(F_btb_PCtarget), .E_valid(E_valid), .E_PC(E_PC),
    .E_branch(E_branch), .E_jal(E_jal), .E_jalr(E_jalr), .E_taken(E_taken),
    .E_PCTarget(E_PCTarget)
  );

  function automatic step_t st(input logic [31:0] pc, input logic [1:0] op, input logic tk,
                               input logic [31:0] tgt, input logic em, input logic et,
                               input logic [31:0] etg);
    step_t s;
    s.pc = pc; s.op = op; s.tk = tk; s.tgt = tgt; s.em = em; s.et = et; s.etg = etg;
    return s;
  endfunction

  task automatic apply_update(input step_t s);
    @(negedge clk);
    E_valid = 1'b1; E_PC = s.pc; E_taken = s.tk; E_PCTarget = s.tgt;
    E_branch = (s.op == OP_BR); E_jal = (s.op == OP_JAL); E_jalr = (s.op == OP_JALR);
    @(posedge clk);
    #1;
    E_valid = 1'b0; E_branch = 1'b0; E_jal = 1'b0; E_jalr = 1'b0;
  endtask

  task automatic expect_lookup(input logic [31:0] pc, input logic m, input logic t,
                               input logic [31:0] tg);
    @(negedge clk);
    F_PC = pc;
    sb.push_back({m, t, tg});
  endtask

  task automatic test_reset();
    rst = 1'b1; E_valid = 1'b0; E_branch = 1'b0; E_jal = 1'b0; E_jalr = 1'b0;
    E_taken = 1'b0; E_PC = '0; E_PCTarget = '0; F_PC = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_lookup(32'h48, 1'b0, 1'b0, 32'h0);
    #1;
    got = {F_prediction_made, F_predicted_taken, F_btb_PCtarget};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_lookup: got made=%b taken=%b tgt=%h, want made=%b taken=%b tgt=%h",
               got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
    end
  endtask

  // Runs a list of update+lookup steps, comparing after each.
  task automatic test_steps(input string name, input step_t steps[$]);
    foreach (steps[i]) begin
      apply_update(steps[i]);
      expect_lookup(steps[i].pc, steps[i].em, steps[i].et, steps[i].etg);
      #1;
      got = {F_prediction_made, F_predicted_taken, F_btb_PCtarget};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s_step%0d pc=%h: got made=%b taken=%b tgt=%h, want made=%b taken=%b tgt=%h",
                 name, i, steps[i].pc, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
      end
    end
  endtask

  task automatic test_allocate();
    step_t s[$];
    s.push_back(st(32'h48, OP_BR, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20));
    test_steps("allocate", s);
    expect_lookup(32'h88, 1'b0, 1'b0, 32'h0);
    #1;
    got = {F_prediction_made, F_predicted_taken, F_btb_PCtarget};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL alias_tag_miss: got made=%b taken=%b tgt=%h, want made=%b taken=%b tgt=%h",
               got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
    end
  endtask

  task automatic test_counter();
    step_t s[$];
    s.push_back(st(32'h48, OP_BR, 1'b0, 32'h5,  1'b1, 1'b0, 32'h20)); // 10->01
    s.push_back(st(32'h48, OP_BR, 1'b0, 32'h5,  1'b1, 1'b0, 32'h20)); // 01->00
    s.push_back(st(32'h48, OP_BR, 1'b1, 32'h20, 1'b1, 1'b0, 32'h20)); // 00->01
    s.push_back(st(32'h48, OP_BR, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20)); // 01->10
    s.push_back(st(32'h48, OP_BR, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20)); // 10->11
    s.push_back(st(32'h48, OP_BR, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20)); // 11 saturates
    s.push_back(st(32'h48, OP_BR, 1'b0, 32'h5,  1'b1, 1'b1, 32'h20)); // 11->10
    s.push_back(st(32'h48, OP_BR, 1'b0, 32'h5,  1'b1, 1'b0, 32'h20)); // 10->01
    s.push_back(st(32'h88, OP_BR, 1'b0, 32'h7,  1'b0, 1'b0, 32'h0));  // not-taken miss: no alloc
    test_steps("counter", s);
  endtask

  task automatic test_jal_jalr();
    step_t s[$];
    s.push_back(st(32'h100, OP_JAL,  1'b0, 32'h200, 1'b1, 1'b1, 32'h200));
    s.push_back(st(32'h100, OP_JALR, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0));
    s.push_back(st(32'h140, OP_JALR, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0));
    s.push_back(st(32'h104, OP_JAL,  1'b0, 32'h250, 1'b1, 1'b1, 32'h250));
    s.push_back(st(32'h104, OP_BR,   1'b0, 32'h0,   1'b1, 1'b1, 32'h250)); // 11->10, is_jal cleared
    s.push_back(st(32'h104, OP_BR,   1'b0, 32'h0,   1'b1, 1'b0, 32'h250)); // 10->01
    test_steps("jal_jalr", s);
  endtask

  task automatic test_same_cycle();
    // Entry at 0x48 holds ctr=01, target 0x20.
    @(negedge clk);
    E_valid = 1'b1; E_PC = 32'h48; E_branch = 1'b1; E_taken = 1'b1; E_PCTarget = 32'h30;
    F_PC = 32'h48;
    sb.push_back({1'b1, 1'b0, 32'h20});
    #1;
    got = {F_prediction_made, F_predicted_taken, F_btb_PCtarget};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL same_cycle_old: got made=%b taken=%b tgt=%h, want made=%b taken=%b tgt=%h",
               got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
    end
    @(posedge clk);
    #1 E_valid = 1'b0; E_branch = 1'b0;
    expect_lookup(32'h48, 1'b1, 1'b1, 32'h30);
    #1;
    got = {F_prediction_made, F_predicted_taken, F_btb_PCtarget};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL same_cycle_new: got made=%b taken=%b tgt=%h, want made=%b taken=%b tgt=%h",
               got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
    end
    // Bubbles carrying branch info must not train.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      E_valid = 1'b0; E_PC = 32'h48; E_branch = 1'b1;
      E_taken = (k == 0); E_PCTarget = 32'h44;
      @(posedge clk);
      #1 E_branch = 1'b0;
      expect_lookup(32'h48, 1'b1, 1'b1, 32'h30);
      #1;
      got = {F_prediction_made, F_predicted_taken, F_btb_PCtarget};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bubble_no_train_%0d: got made=%b taken=%b tgt=%h, want made=%b taken=%b tgt=%h",
                 k, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] pcs[$];
    logic [31:0] tgts[$];
    pcs  = '{32'h10, 32'h14, 32'h18};
    tgts = '{32'hA0, 32'hB0, 32'hC0};
    // Consecutive updates with no idle cycle between them.
    @(negedge clk);
    E_valid = 1'b1;
    foreach (pcs[i]) begin
      E_PC = pcs[i]; E_PCTarget = tgts[i]; E_taken = 1'b1;
      E_branch = (i != 2); E_jal = (i == 2);
      @(negedge clk);
    end
    E_valid = 1'b0; E_branch = 1'b0; E_jal = 1'b0;
    foreach (pcs[i]) begin
      expect_lookup(pcs[i], 1'b1, 1'b1, tgts[i]);
      #1;
      got = {F_prediction_made, F_predicted_taken, F_btb_PCtarget};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_fill_%0d: got made=%b taken=%b tgt=%h, want made=%b taken=%b tgt=%h",
                 i, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
      end
    end
    // Reset coincident with a valid update: reset wins.
    @(negedge clk);
    rst = 1'b1; E_valid = 1'b1; E_PC = 32'h1C; E_branch = 1'b1; E_taken = 1'b1;
    E_PCTarget = 32'h99;
    @(posedge clk);
    #1 rst = 1'b0; E_valid = 1'b0; E_branch = 1'b0;
    pcs.push_back(32'h48);
    pcs.push_back(32'h1C);
    foreach (pcs[i]) begin
      expect_lookup(pcs[i], 1'b0, 1'b0, 32'h0);
      #1;
      got = {F_prediction_made, F_predicted_taken, F_btb_PCtarget};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL post_reset_%0d pc=%h: got made=%b taken=%b tgt=%h, want made=0 taken=0 tgt=0",
                 i, pcs[i], got[33], got[32], got[31:0]);
      end
    end
`ifdef BTB_GSHARE_EN
    checks++;
    if (dut.ghr_q !== '0) begin
      errors++;
      $display("FAIL ghr_reset: got %h want 0", dut.ghr_q);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_jal_jalr();
    test_same_cycle();
    test_back_to_back_reset();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
